// File: rtl/ram_store_seq.sv
// ram_store_seq: sequences a left-aligned 64-bit store into big-endian byte writes.
// Optional feature: define RAM_ALIGN_CHECK_EN to reject misaligned requests with an err pulse.
package ram_store_pkg;
    typedef enum logic [2:0] {
        RAM_QUAD = 3'd0,
        RAM_LONG = 3'd1,
        RAM_WORD = 3'd2,
        RAM_BYTE = 3'd3
    } data_type_t;
endpackage

module ram_store_seq
    import ram_store_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [63:0]       i_req_data,
    input  data_type_t        i_req_type,
    output logic              o_ram_we,
    input  logic              i_ram_gnt,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_wdata,
    output logic              o_done,
    output logic              o_err
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_data;
    logic [2:0]        r_cnt;
    logic              r_done, r_err;
    logic [2:0]        w_last;
    logic              w_accept, w_misalign, w_start, w_gnt, w_fin;

    // index of the final byte (N-1); unknown encodings behave as a quad
    always_comb begin
        w_last = (i_req_type == RAM_BYTE) ? 3'd0 :
                 (i_req_type == RAM_WORD) ? 3'd1 :
                 (i_req_type == RAM_LONG) ? 3'd3 : 3'd7;
    end

    assign w_accept = i_req_valid && (r_state == S_IDLE);
`ifdef RAM_ALIGN_CHECK_EN
    assign w_misalign = (i_req_addr[2:0] & w_last) != 3'd0;
`else
    assign w_misalign = 1'b0;
`endif
    assign w_start = w_accept && !w_misalign;
    assign w_gnt   = (r_state == S_SEND) && i_ram_gnt;
    assign w_fin   = w_gnt && (r_cnt == 3'd0);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state: start on an accepted aligned request, return after the last grant
    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? (w_start ? S_SEND : S_IDLE) :
                 (w_fin ? S_IDLE : S_SEND);
    end

    // address/data shifter: current byte always sits at the top of r_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr <= i_req_addr;
                r_data <= i_req_data;
                r_cnt  <= w_last;
            end else if (w_gnt) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_data <= {r_data[55:0], 8'h00};
                r_cnt  <= r_cnt - 3'd1;
            end
            r_done <= w_fin;
            r_err  <= w_accept && w_misalign;
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_ram_we    = (r_state == S_SEND);
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_data[63:56];
    assign o_done      = r_done;
    assign o_err       = r_err;
endmodule

// File: tb/tb_ram_store_seq.sv
// tb_ram_store_seq: directed and randomized store requests checked against a byte-list model.
module tb_ram_store_seq;
    import ram_store_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [15:0] i_req_addr = '0;
    logic [63:0] i_req_data = '0;
    data_type_t  i_req_type = RAM_QUAD;
    logic        o_ram_we;
    logic        i_ram_gnt = 1'b0;
    logic [15:0] o_ram_addr;
    logic [7:0]  o_ram_wdata;
    logic        o_done;
    logic        o_err;

    int n_chk = 0;
    int n_fail = 0;

    ram_store_seq #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_type(i_req_type),
        .o_ram_we(o_ram_we), .i_ram_gnt(i_ram_gnt),
        .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        case (t)
            3'd3:    return 1;
            3'd2:    return 2;
            3'd1:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit misaligned(input logic [15:0] a, input logic [2:0] t);
`ifdef RAM_ALIGN_CHECK_EN
        return (int'(a) % nbytes(t)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_ram_gnt = 1'($urandom);
            tick();
            check("idle_we", o_ram_we, 0);
            check("idle_done", o_done, 0);
            check("idle_err", o_err, 0);
            check("idle_ready", o_req_ready, 1);
        end
    endtask

    // presents one request at the current negedge and follows it to done/err
    task automatic run_req(input logic [15:0] a, input logic [63:0] d, input logic [2:0] t,
                           input int pct, input int stall_at, input int stall_n);
        int n, i, cycles, stalls;
        logic [15:0] ea;
        bit g;
        n = nbytes(t);
        check("accept_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
        i_req_type  = data_type_t'(t);
        tick();
        if (misaligned(a, t)) begin
            i_req_valid = 1'b0;
            check("mis_err", o_err, 1);
            check("mis_done", o_done, 0);
            check("mis_we", o_ram_we, 0);
            check("mis_ready", o_req_ready, 1);
            return;
        end
        i = 0;
        cycles = 0;
        stalls = 0;
        while (i < n && cycles < 300) begin
            ea = a + 16'(i);
            check("we", o_ram_we, 1);
            check("addr", o_ram_addr, ea);
            check("wdata", o_ram_wdata, d[63-8*i -: 8]);
            check("busy_ready", o_req_ready, 0);
            check("busy_done", o_done, 0);
            i_req_valid = 1'($urandom);
            i_req_addr  = 16'($urandom);
            i_req_data  = {$urandom, $urandom};
            i_req_type  = data_type_t'(3'($urandom));
            g = (i == stall_at && stalls < stall_n) ? 1'b0 : ($urandom_range(99) < pct);
            if (!g) stalls++;
            i_ram_gnt = g;
            tick();
            if (g) i++;
            cycles++;
        end
        i_req_valid = 1'b0;
        i_ram_gnt = 1'b0;
        check("bytes_written", i, n);
        check("we_cycles", cycles, n + stalls);
        check("done", o_done, 1);
        check("done_err", o_err, 0);
        check("done_we", o_ram_we, 0);
        check("done_ready", o_req_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", o_req_ready, 1);
        check("rst_we", o_ram_we, 0);
        check("rst_addr", o_ram_addr, 0);
        check("rst_wdata", o_ram_wdata, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        rst_n = 1'b1;
        idle(2);

        run_req(16'h0010, 64'h0123456789ABCDEF, RAM_QUAD, 100, -1, 0);
        idle(1);
        run_req(16'h0005, 64'hA5FFFFFFFFFFFFFF, RAM_BYTE, 100, -1, 0);
        run_req(16'h0006, 64'hBEEF123456789ABC, RAM_WORD, 100, -1, 0);
        idle(1);
        run_req(16'h0020, 64'h11223344AABBCCDD, RAM_LONG, 100, 1, 3);
        idle(1);
        run_req(16'hFFFC, 64'hFEDCBA9876543210, RAM_QUAD, 100, -1, 0);
        idle(1);
        run_req(16'h0002, 64'hCAFEF00D00000000, RAM_LONG, 100, -1, 0);
        idle(1);
        run_req(16'h0040, 64'h0807060504030201, 3'd6, 100, -1, 0);
        idle(1);

        for (int r = 0; r < 60; r++) begin
            run_req(16'($urandom), {$urandom, $urandom}, 3'($urandom),
                    ($urandom_range(1) != 0) ? 100 : 50, -1, 0);
            idle($urandom_range(2));
        end

        // asynchronous reset while byte 3 of a quad is on the port
        check("arst_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0100;
        i_req_data  = 64'h0011223344556677;
        i_req_type  = RAM_QUAD;
        tick();
        i_req_valid = 1'b0;
        i_ram_gnt   = 1'b1;
        repeat (3) tick();
        check("arst_pre_addr", o_ram_addr, 16'h0103);
        check("arst_pre_wdata", o_ram_wdata, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", o_ram_we, 0);
        check("arst_addr", o_ram_addr, 0);
        check("arst_wdata", o_ram_wdata, 0);
        check("arst_ready", o_req_ready, 1);
        check("arst_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_we", o_ram_we, 0);
            check("post_rst_done", o_done, 0);
        end
        i_ram_gnt = 1'b0;
        run_req(16'h0200, 64'h5A5A000000000000, RAM_WORD, 100, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
